// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the synchronous instruction ROM and hands
// {instr, PC+1, valid} to decode. Handles redirects, decode stalls via a one-entry skid buffer, and squashing.
module fetch_stage #(
    parameter int              AW       = 12,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] ROM_data,
    input  logic          stall_i,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          jr_en,
    input  logic [DW-1:0] jr_addr,
    input  logic          branch_en,
    input  logic [AW-1:0] branch_base,
    input  logic [5:0]    branch_offset,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc1,
    output logic          if_valid
);

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_e;

    localparam logic [DW-1:0] NOP = '0;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_pc1_q, pend_pc1_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_pc1_q, skid_pc1_d;
    logic [DW-1:0] if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc1_q, if_pc1_d;
    logic          if_valid_q, if_valid_d;

    logic          redirect;
    logic          redirect_act;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_plus1;
    logic          unused_jr_hi;

    // Only the low AW bits of a register value can address the ROM.
    assign unused_jr_hi = ^jr_addr[DW-1:AW];

    assign redirect     = jump_en | jr_en | branch_en;
    assign redirect_act = redirect && (state_q != BOOT);
    assign pc_plus1     = pc_q + AW'(1);
    assign rom_addr     = pc_q;

    always_comb begin
        if (jr_en)
            target = jr_addr[AW-1:0];
        else if (jump_en)
            target = jump_addr;
        else
            target = branch_base + {{(AW-6){branch_offset[5]}}, branch_offset};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = redirect ? FLUSH : FETCH;
            FLUSH:   state_d = redirect ? FLUSH : FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        rom_rd = (state_q == FETCH) && !stall_i && !redirect;
    end

    // NOTE: every next-state signal gets a hold default first so no latch is inferred.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = 1'b0;
        pend_pc1_d   = pend_pc1_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc1_d   = skid_pc1_q;
        if_instr_d   = if_instr_q;
        if_pc1_d     = if_pc1_q;
        if_valid_d   = if_valid_q;

        if (redirect_act) begin
            // Wrong-path work in flight or parked in the skid is dropped.
            pc_d         = target;
            skid_valid_d = 1'b0;
            if_valid_d   = 1'b0;
            if_instr_d   = NOP;
        end else begin
            if (rom_rd) begin
                pc_d       = pc_plus1;
                pend_d     = 1'b1;
                pend_pc1_d = pc_plus1;
            end
            if (stall_i) begin
                if (pend_q) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = ROM_data;
                    skid_pc1_d   = pend_pc1_q;
                end
            end else if (skid_valid_q) begin
                if_instr_d   = skid_instr_q;
                if_pc1_d     = skid_pc1_q;
                if_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (pend_q) begin
                if_instr_d = ROM_data;
                if_pc1_d   = pend_pc1_q;
                if_valid_d = 1'b1;
            end else begin
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end
        end
    end

    // NOTE: the skid payload is reset along with its valid bit; it is a single word, not a memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc1_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc1_q   <= '0;
            if_instr_q   <= NOP;
            if_pc1_q     <= '0;
            if_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc1_q   <= pend_pc1_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc1_q   <= skid_pc1_d;
            if_instr_q   <= if_instr_d;
            if_pc1_q     <= if_pc1_d;
            if_valid_q   <= if_valid_d;
        end
    end

    assign if_instr = if_instr_q;
    assign if_pc1   = if_pc1_q;
    assign if_valid = if_valid_q;

endmodule
